// File: rtl/ps2_keycode_rx.sv
// ps2_keycode_rx: PS/2 keyboard frame receiver assembling prefixed scancodes into a 32-bit key word
module ps2_keycode_rx #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        kbd_clk,
  input  logic        kbd_data,
  output logic [31:0] kbd_key,
  output logic        kbd_key_valid,
  output logic        kbd_err
);
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
  state_t        r_state;
  logic [1:0]    r_clk_s, r_dat_s;
  logic          r_fclk;
  logic [FW-1:0] r_fcnt;
  logic [2:0]    r_cnt;
  logic [7:0]    r_sr;
  logic          r_par;
  logic [23:0]   r_acc;
  logic [TW-1:0] r_tmo;
  logic          w_diff, w_flip, w_fall, w_dat, w_pfx, w_ok;
  assign w_diff = r_clk_s[1] != r_fclk;
  assign w_flip = w_diff && (r_fcnt == FW'(FILTER_LEN - 1));
  assign w_fall = w_flip && r_fclk;
  assign w_dat  = r_dat_s[1];
  assign w_pfx  = (r_sr == 8'hE0) || (r_sr == 8'hF0) || (r_sr == 8'hE1);
  assign w_ok   = w_dat && (^{r_sr, r_par});
  always_ff @(posedge clk) begin
    if (reset) begin
      r_clk_s <= 2'b11;
      r_dat_s <= 2'b11;
      r_fclk  <= 1'b1;
      r_fcnt  <= '0;
    end else begin
      r_clk_s <= {r_clk_s[0], kbd_clk};
      r_dat_s <= {r_dat_s[0], kbd_data};
      r_fclk  <= w_flip ? ~r_fclk : r_fclk;
      r_fcnt  <= (!w_diff || w_flip) ? '0 : r_fcnt + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= IDLE;
      r_cnt         <= '0;
      r_sr          <= '0;
      r_par         <= 1'b0;
      r_acc         <= '0;
      r_tmo         <= '0;
      kbd_key       <= '0;
      kbd_key_valid <= 1'b0;
      kbd_err       <= 1'b0;
    end else begin
      kbd_key_valid <= 1'b0;
      kbd_err       <= 1'b0;
      if (r_state == IDLE) begin
        r_tmo <= '0;
        if (w_fall && !w_dat) begin
          r_state <= DATA;
          r_cnt   <= '0;
          r_sr    <= '0;
        end
      end else if (!w_fall) begin
        // a stalled frame drops everything, including pending prefixes
        if (r_tmo == TW'(TIMEOUT_CYCLES - 1)) begin
          kbd_err <= 1'b1;
          r_state <= IDLE;
          r_acc   <= '0;
          r_sr    <= '0;
          r_cnt   <= '0;
          r_tmo   <= '0;
        end else begin
          r_tmo <= r_tmo + 1'b1;
        end
      end else begin
        r_tmo <= '0;
        case (r_state)
          DATA: begin
            r_sr    <= {w_dat, r_sr[7:1]};
            r_cnt   <= r_cnt + 1'b1;
            r_state <= (r_cnt == 3'd7) ? PARITY : DATA;
          end
          PARITY: begin
            r_par   <= w_dat;
            r_state <= STOP;
          end
          default: begin
            r_state <= IDLE;
            if (!w_ok) begin
              kbd_err <= 1'b1;
              r_acc   <= '0;
            end else if (w_pfx) begin
              r_acc <= {r_acc[15:0], r_sr};
            end else begin
              kbd_key       <= {r_acc, r_sr};
              kbd_key_valid <= 1'b1;
              r_acc         <= '0;
            end
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_ps2_keycode_rx.sv
// tb_ps2_keycode_rx: scoreboard bench driving PS/2 frames and checking assembled key words and error strobes
module tb_ps2_keycode_rx;
  localparam int FL   = 4;
  localparam int TO   = 200;
  localparam int HALF = 20;
  localparam int LAT  = 2 + FL;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        kbd_clk = 1'b1;
  logic        kbd_data = 1'b1;
  logic [31:0] kbd_key;
  logic        kbd_key_valid, kbd_err;
  int n_tests = 0, n_fail = 0;
  int cyc = 0, t_stop = 0, t_valid = 0, n_err = 0, n_both = 0, rd = 0;
  logic [31:0] got_q[$];
  logic [31:0] exp_q[$];

  ps2_keycode_rx #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .kbd_clk(kbd_clk), .kbd_data(kbd_data),
    .kbd_key(kbd_key), .kbd_key_valid(kbd_key_valid), .kbd_err(kbd_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (!reset) begin
    if (kbd_key_valid) begin
      got_q.push_back(kbd_key);
      t_valid = cyc;
    end
    if (kbd_err) n_err++;
    if (kbd_key_valid && kbd_err) n_both++;
  end

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit pflip = 1'b0, input bit stop = 1'b1,
                            input bit gl = 1'b0, input int nbits = 11);
    logic [10:0] fr;
    fr = {stop, (~^b) ^ pflip, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      kbd_data = fr[i];
      wait_clks(HALF / 2);
      if (gl) begin
        kbd_clk = 1'b0;
        wait_clks(2);
        kbd_clk = 1'b1;
      end
      wait_clks(HALF / 2);
      kbd_clk = 1'b0;
      if (i == 10) t_stop = cyc;
      wait_clks(HALF / 2);
      if (gl) begin
        kbd_clk = 1'b1;
        wait_clks(2);
        kbd_clk = 1'b0;
      end
      wait_clks(HALF / 2);
      kbd_clk = 1'b1;
    end
    kbd_data = 1'b1;
    wait_clks(HALF);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    wait_clks(5);
    n_tests++;
    if (kbd_key !== 32'h0) begin n_fail++; $display("FAIL reset_key got %h expected %h", kbd_key, 32'h0); end
    n_tests++;
    if (kbd_key_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b expected 0", kbd_key_valid); end
    n_tests++;
    if (kbd_err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b expected 0", kbd_err); end
    reset = 1'b0;
    wait_clks(5);
  endtask

  task automatic test_single;
    int e0 = n_err;
    logic [31:0] e;
    send_frame(8'h1C);
    exp_q.push_back(32'h0000001C);
    wait_clks(60);
    n_tests++;
    if (got_q.size() - rd !== exp_q.size()) begin n_fail++; $display("FAIL single_count got %0d expected %0d", got_q.size() - rd, exp_q.size()); end
    while (exp_q.size() > 0 && rd < got_q.size()) begin
      e = exp_q.pop_front(); n_tests++;
      if (got_q[rd] !== e) begin n_fail++; $display("FAIL single_key got %h expected %h", got_q[rd], e); end
      rd++;
    end
    rd = got_q.size(); exp_q.delete();
    n_tests++;
    if (t_valid - t_stop !== LAT) begin n_fail++; $display("FAIL single_latency got %0d expected %0d", t_valid - t_stop, LAT); end
    n_tests++;
    if (n_err - e0 !== 0) begin n_fail++; $display("FAIL single_err got %0d expected 0", n_err - e0); end
    n_tests++;
    if (kbd_key !== 32'h0000001C) begin n_fail++; $display("FAIL single_hold got %h expected %h", kbd_key, 32'h0000001C); end
  endtask

  task automatic test_prefix;
    int e0 = n_err;
    logic [31:0] e;
    kbd_data = 1'b1;
    wait_clks(HALF);
    kbd_clk = 1'b0;
    wait_clks(HALF);
    kbd_clk = 1'b1;
    wait_clks(HALF);
    send_frame(8'hF0); send_frame(8'h1C); exp_q.push_back(32'h0000F01C);
    send_frame(8'hE0); send_frame(8'hF0); send_frame(8'h75); exp_q.push_back(32'h00E0F075);
    send_frame(8'h74); exp_q.push_back(32'h00000074);
    send_frame(8'hE0); send_frame(8'hF0); send_frame(8'hE1); send_frame(8'hE0);
    send_frame(8'h12); exp_q.push_back(32'hF0E1E012);
    wait_clks(60);
    n_tests++;
    if (got_q.size() - rd !== exp_q.size()) begin n_fail++; $display("FAIL prefix_count got %0d expected %0d", got_q.size() - rd, exp_q.size()); end
    while (exp_q.size() > 0 && rd < got_q.size()) begin
      e = exp_q.pop_front(); n_tests++;
      if (got_q[rd] !== e) begin n_fail++; $display("FAIL prefix_key got %h expected %h", got_q[rd], e); end
      rd++;
    end
    rd = got_q.size(); exp_q.delete();
    n_tests++;
    if (n_err - e0 !== 0) begin n_fail++; $display("FAIL prefix_err got %0d expected 0", n_err - e0); end
  endtask

  task automatic test_pause;
    logic [31:0] e;
    send_frame(8'hE1); send_frame(8'h14); exp_q.push_back(32'h0000E114);
    send_frame(8'h77); exp_q.push_back(32'h00000077);
    send_frame(8'hE1); send_frame(8'hF0); send_frame(8'h14); exp_q.push_back(32'h00E1F014);
    send_frame(8'hF0); send_frame(8'h77); exp_q.push_back(32'h0000F077);
    wait_clks(60);
    n_tests++;
    if (got_q.size() - rd !== exp_q.size()) begin n_fail++; $display("FAIL pause_count got %0d expected %0d", got_q.size() - rd, exp_q.size()); end
    while (exp_q.size() > 0 && rd < got_q.size()) begin
      e = exp_q.pop_front(); n_tests++;
      if (got_q[rd] !== e) begin n_fail++; $display("FAIL pause_key got %h expected %h", got_q[rd], e); end
      rd++;
    end
    rd = got_q.size(); exp_q.delete();
  endtask

  task automatic test_errors;
    int e0 = n_err;
    logic [31:0] e;
    send_frame(8'hE0);
    send_frame(8'h1C, 1'b1);
    wait_clks(10);
    n_tests++;
    if (n_err - e0 !== 1) begin n_fail++; $display("FAIL parity_err got %0d expected 1", n_err - e0); end
    n_tests++;
    if (kbd_key !== 32'h0000F077) begin n_fail++; $display("FAIL parity_hold got %h expected %h", kbd_key, 32'h0000F077); end
    send_frame(8'h1C); exp_q.push_back(32'h0000001C);
    send_frame(8'hF0);
    send_frame(8'h1C, 1'b0, 1'b0);
    wait_clks(10);
    n_tests++;
    if (n_err - e0 !== 2) begin n_fail++; $display("FAIL stop_err got %0d expected 2", n_err - e0); end
    send_frame(8'h29); exp_q.push_back(32'h00000029);
    wait_clks(60);
    n_tests++;
    if (got_q.size() - rd !== exp_q.size()) begin n_fail++; $display("FAIL errors_count got %0d expected %0d", got_q.size() - rd, exp_q.size()); end
    while (exp_q.size() > 0 && rd < got_q.size()) begin
      e = exp_q.pop_front(); n_tests++;
      if (got_q[rd] !== e) begin n_fail++; $display("FAIL errors_key got %h expected %h", got_q[rd], e); end
      rd++;
    end
    rd = got_q.size(); exp_q.delete();
  endtask

  task automatic test_timeout;
    int e0 = n_err;
    logic [31:0] e;
    send_frame(8'hE0);
    send_frame(8'h5A, 1'b0, 1'b1, 1'b0, 5);
    wait_clks(TO + 100);
    n_tests++;
    if (n_err - e0 !== 1) begin n_fail++; $display("FAIL timeout_err got %0d expected 1", n_err - e0); end
    send_frame(8'h29); exp_q.push_back(32'h00000029);
    wait_clks(60);
    n_tests++;
    if (got_q.size() - rd !== exp_q.size()) begin n_fail++; $display("FAIL timeout_count got %0d expected %0d", got_q.size() - rd, exp_q.size()); end
    while (exp_q.size() > 0 && rd < got_q.size()) begin
      e = exp_q.pop_front(); n_tests++;
      if (got_q[rd] !== e) begin n_fail++; $display("FAIL timeout_key got %h expected %h", got_q[rd], e); end
      rd++;
    end
    rd = got_q.size(); exp_q.delete();
  endtask

  task automatic test_glitch;
    int e0 = n_err;
    logic [31:0] e;
    send_frame(8'h1C, 1'b0, 1'b1, 1'b1);
    exp_q.push_back(32'h0000001C);
    wait_clks(60);
    n_tests++;
    if (got_q.size() - rd !== exp_q.size()) begin n_fail++; $display("FAIL glitch_count got %0d expected %0d", got_q.size() - rd, exp_q.size()); end
    while (exp_q.size() > 0 && rd < got_q.size()) begin
      e = exp_q.pop_front(); n_tests++;
      if (got_q[rd] !== e) begin n_fail++; $display("FAIL glitch_key got %h expected %h", got_q[rd], e); end
      rd++;
    end
    rd = got_q.size(); exp_q.delete();
    n_tests++;
    if (n_err - e0 !== 0) begin n_fail++; $display("FAIL glitch_err got %0d expected 0", n_err - e0); end
  endtask

  task automatic test_reset_midframe;
    int e0;
    logic [31:0] e;
    send_frame(8'hE0);
    send_frame(8'h55, 1'b0, 1'b1, 1'b0, 5);
    reset = 1'b1;
    wait_clks(5);
    reset = 1'b0;
    wait_clks(2);
    e0 = n_err;
    n_tests++;
    if (kbd_key !== 32'h0) begin n_fail++; $display("FAIL midreset_key got %h expected %h", kbd_key, 32'h0); end
    wait_clks(TO + 50);
    send_frame(8'h1C); exp_q.push_back(32'h0000001C);
    wait_clks(60);
    n_tests++;
    if (got_q.size() - rd !== exp_q.size()) begin n_fail++; $display("FAIL midreset_count got %0d expected %0d", got_q.size() - rd, exp_q.size()); end
    while (exp_q.size() > 0 && rd < got_q.size()) begin
      e = exp_q.pop_front(); n_tests++;
      if (got_q[rd] !== e) begin n_fail++; $display("FAIL midreset_key2 got %h expected %h", got_q[rd], e); end
      rd++;
    end
    rd = got_q.size(); exp_q.delete();
    n_tests++;
    if (n_err - e0 !== 0) begin n_fail++; $display("FAIL midreset_err got %0d expected 0", n_err - e0); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_prefix();
    test_pause();
    test_errors();
    test_timeout();
    test_glitch();
    test_reset_midframe();
    n_tests++;
    if (n_both !== 0) begin n_fail++; $display("FAIL valid_err_overlap got %0d expected 0", n_both); end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
